// File: rtl/bitmap_index_fetch_pkg.sv
// rtl/bitmap_index_fetch_pkg.sv - shared VGA bitmap geometry, pipeline depth and sync polarity
package bitmap_index_fetch_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int SCALE_SHIFT = 2;
  localparam int BMP_W       = H_ACTIVE >> SCALE_SHIFT;
  localparam int BMP_H       = V_ACTIVE >> SCALE_SHIFT;
  localparam int ROW_BYTES   = BMP_W / 2;
  localparam int ADDR_W      = $clog2(BMP_W * BMP_H / 2);
  localparam int PIPE_LAT    = 3;

  localparam logic SYNC_ACTIVE = 1'b0;
  localparam logic SYNC_IDLE   = ~SYNC_ACTIVE;

  typedef struct packed {
    logic sel;
    logic active;
    logic hsync;
    logic vsync;
  } pix_ctl_t;

  localparam pix_ctl_t CTL_RST = '{sel: 1'b0, active: 1'b0, hsync: SYNC_IDLE, vsync: SYNC_IDLE};

endpackage

// File: rtl/bitmap_index_fetch_if.sv
// rtl/bitmap_index_fetch_if.sv - synchronous bitmap memory read port
interface bitmap_index_fetch_if;
  import bitmap_index_fetch_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  modport master (output mem_addr, input mem_data);
  modport slave  (input mem_addr, output mem_data);

endinterface

// File: rtl/bitmap_index_fetch_sync_delay.sv
// rtl/bitmap_index_fetch_sync_delay.sv - N-stage shift register with a parameterised reset value
module bitmap_index_fetch_sync_delay #(
  parameter int               WIDTH   = 4,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [WIDTH-1:0] stage_q [DEPTH];

  always_comb begin
    stage_d[0] = i_d;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign o_q = stage_q[DEPTH-1];

endmodule

// File: rtl/bitmap_index_fetch.sv
// rtl/bitmap_index_fetch.sv - VGA coordinates to 4-bpp bitmap byte fetch and nibble select, 3-clock latency
// Define BITMAP_FETCH_HIGH_NIBBLE_FIRST_EN to take the left pixel from data[7:4].
module bitmap_index_fetch
  import bitmap_index_fetch_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [9:0]                  i_col,
  input  logic [9:0]                  i_row,
  input  logic                        i_active,
  input  logic                        i_hsync,
  input  logic                        i_vsync,
  bitmap_index_fetch_if.master        mem,
  output logic [3:0]                  o_index,
  output logic                        o_active,
  output logic                        o_hsync,
  output logic                        o_vsync
);

`ifdef BITMAP_FETCH_HIGH_NIBBLE_FIRST_EN
  localparam logic HI_FIRST = 1'b1;
`else
  localparam logic HI_FIRST = 1'b0;
`endif

  logic              frame_start;
  logic              line_end;
  logic [ADDR_W-1:0] row_base_d, row_base_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic              active_prev_d, active_prev_q;
  logic [3:0]        index_d, index_q;
  logic [3:0]        nibble;
  pix_ctl_t          ctl_s0, ctl_s2;
  logic [2:0]        out_ctl;

  always_comb begin
    frame_start   = (i_row == 10'd0) && (i_col == 10'd0);
    line_end      = active_prev_q && !i_active && (i_row[1:0] == 2'd3);
    row_base_d    = row_base_q;
    if (frame_start) begin
      row_base_d = {ADDR_W{1'b0}};
    end else if (line_end) begin
      row_base_d = row_base_q + ADDR_W'(ROW_BYTES);
    end
    // The base may still hold last frame's end value on the frame-start cycle.
    mem_addr_d    = (frame_start ? {ADDR_W{1'b0}} : row_base_q) + ADDR_W'(i_col[9:3]);
    active_prev_d = i_active;
    ctl_s0        = '{sel: i_col[2], active: i_active, hsync: i_hsync, vsync: i_vsync};
  end

  bitmap_index_fetch_sync_delay #(
    .WIDTH   (4),
    .DEPTH   (PIPE_LAT - 1),
    .RST_VAL (CTL_RST)
  ) u_ctl_delay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (ctl_s0),
    .o_q     (ctl_s2)
  );

  always_comb begin
    nibble  = (ctl_s2.sel ^ HI_FIRST) ? mem.mem_data[7:4] : mem.mem_data[3:0];
    index_d = ctl_s2.active ? nibble : 4'd0;
  end

  bitmap_index_fetch_sync_delay #(
    .WIDTH   (3),
    .DEPTH   (1),
    .RST_VAL ({1'b0, SYNC_IDLE, SYNC_IDLE})
  ) u_out_delay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     ({ctl_s2.active, ctl_s2.hsync, ctl_s2.vsync}),
    .o_q     (out_ctl)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_base_q    <= {ADDR_W{1'b0}};
      mem_addr_q    <= {ADDR_W{1'b0}};
      active_prev_q <= 1'b0;
      index_q       <= 4'd0;
    end else begin
      row_base_q    <= row_base_d;
      mem_addr_q    <= mem_addr_d;
      active_prev_q <= active_prev_d;
      index_q       <= index_d;
    end
  end

  assign mem.mem_addr = mem_addr_q;
  assign o_index      = index_q;
  assign o_active     = out_ctl[2];
  assign o_hsync      = out_ctl[1];
  assign o_vsync      = out_ctl[0];

endmodule

// File: tb/tb_bitmap_index_fetch.sv
// tb/tb_bitmap_index_fetch.sv - directed self-checking bench for bitmap_index_fetch
module tb_bitmap_index_fetch;

`ifdef BITMAP_FETCH_HIGH_NIBBLE_FIRST_EN
  localparam bit HI = 1'b1;
`else
  localparam bit HI = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] col, row;
  logic       act, hs, vs;
  logic [3:0] o_index;
  logic       o_active, o_hsync, o_vsync;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  bitmap_index_fetch_if mif ();

  bitmap_index_fetch dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_col    (col),
    .i_row    (row),
    .i_active (act),
    .i_hsync  (hs),
    .i_vsync  (vs),
    .mem      (mif),
    .o_index  (o_index),
    .o_active (o_active),
    .o_hsync  (o_hsync),
    .o_vsync  (o_vsync)
  );

  function automatic logic [7:0] mem_byte(input logic [13:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  always @(posedge clk) mif.mem_data <= mem_byte(mif.mem_addr);

  task automatic drive(input int c, input int r, input logic a, input logic h, input logic v);
    col = 10'(c);
    row = 10'(r);
    act = a;
    hs  = h;
    vs  = v;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(100, 5, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    total++;
    if (mif.mem_addr !== 14'd0 || o_index !== 4'd0 || o_active !== 1'b0 || o_hsync !== 1'b1 || o_vsync !== 1'b1) begin
      bad++;
      $display("FAIL reset_state got addr=%0d idx=%0d act=%0b hs=%0b vs=%0b want 0 0 0 1 1",
               mif.mem_addr, o_index, o_active, o_hsync, o_vsync);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (o_index !== 4'd0 || o_active !== 1'b0 || o_hsync !== 1'b1 || o_vsync !== 1'b1) begin
        bad++;
        $display("FAIL idle_after_reset cyc=%0d got idx=%0d act=%0b hs=%0b vs=%0b want 0 0 1 1",
                 i, o_index, o_active, o_hsync, o_vsync);
      end
    end
  endtask

  task automatic test_frame_start;
    logic [3:0] exp;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= 8) begin
        total++;
        if (mif.mem_addr !== 14'd0) begin
          bad++;
          $display("FAIL frame_addr col=%0d got=%0d want=0", i - 1, mif.mem_addr);
        end
      end
      if (i >= 3 && i <= 10) begin
        exp = ((i - 3) < 4) ? (HI ? 4'd10 : 4'd5) : (HI ? 4'd5 : 4'd10);
        total++;
        if (o_index !== exp || o_active !== 1'b1) begin
          bad++;
          $display("FAIL frame_index col=%0d got idx=%0d act=%0b want idx=%0d act=1", i - 3, o_index, o_active, exp);
        end
      end
      if (i >= 11) begin
        total++;
        if (o_index !== 4'd0 || o_active !== 1'b0) begin
          bad++;
          $display("FAIL frame_blank cyc=%0d got idx=%0d act=%0b want 0 0", i, o_index, o_active);
        end
      end
      if (i < 8) drive(i, 0, 1'b1, 1'b1, 1'b1);
      else drive(8, 0, 1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic test_row_advance;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      drive(8, r, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      total++;
      if (mif.mem_addr !== 14'd1) begin
        bad++;
        $display("FAIL row_addr row=%0d got=%0d want=1", r, mif.mem_addr);
      end
      drive(9, r, 1'b0, 1'b1, 1'b1);
    end
    @(negedge clk);
    drive(8, 4, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (mif.mem_addr !== 14'd81) begin
      bad++;
      $display("FAIL row4_col8_addr got=%0d want=81", mif.mem_addr);
    end
    drive(12, 4, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (mif.mem_addr !== 14'd81) begin
      bad++;
      $display("FAIL row4_col12_addr got=%0d want=81", mif.mem_addr);
    end
    drive(13, 4, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (o_index !== (HI ? 4'd15 : 4'd4) || o_active !== 1'b1) begin
      bad++;
      $display("FAIL row4_col8_index got idx=%0d act=%0b want idx=%0d act=1", o_index, o_active, HI ? 15 : 4);
    end
    drive(14, 4, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (o_index !== (HI ? 4'd4 : 4'd15) || o_active !== 1'b1) begin
      bad++;
      $display("FAIL row4_col12_index got idx=%0d act=%0b want idx=%0d act=1", o_index, o_active, HI ? 4 : 15);
    end
    drive(15, 4, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (o_index !== 4'd0 || o_active !== 1'b0) begin
      bad++;
      $display("FAIL row4_blank got idx=%0d act=%0b want 0 0", o_index, o_active);
    end
    for (int r = 5; r < 479; r++) begin
      drive(8, r, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      drive(9, r, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
    end
    drive(639, 479, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (mif.mem_addr !== 14'd9599) begin
      bad++;
      $display("FAIL last_pixel_addr got=%0d want=9599", mif.mem_addr);
    end
    drive(639, 479, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    total++;
    if (o_index !== (HI ? 4'd10 : 4'd13) || o_active !== 1'b1) begin
      bad++;
      $display("FAIL last_pixel_index got idx=%0d act=%0b want idx=%0d act=1", o_index, o_active, HI ? 10 : 13);
    end
  endtask

  task automatic test_hsync;
    int   lows;
    int   first_low;
    logic exp_hs, exp_act;
    lows = 0;
    first_low = -1;
    for (int i = 0; i < 126; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        exp_hs  = !((i - 3) >= 10 && (i - 3) < 106);
        exp_act = !((i - 3) >= 5 && (i - 3) < 115);
        total++;
        if (o_hsync !== exp_hs || o_active !== exp_act || o_vsync !== 1'b1) begin
          bad++;
          $display("FAIL hsync_align cyc=%0d got hs=%0b act=%0b vs=%0b want hs=%0b act=%0b vs=1",
                   i, o_hsync, o_active, o_vsync, exp_hs, exp_act);
        end
      end
      if (o_hsync === 1'b0) begin
        lows++;
        if (first_low < 0) first_low = i;
      end
      drive(100 + i, 10, !(i >= 5 && i < 115), !(i >= 10 && i < 106), 1'b1);
    end
    total++;
    if (lows != 96 || first_low != 13) begin
      bad++;
      $display("FAIL hsync_width got low=%0d first=%0d want low=96 first=13", lows, first_low);
    end
  endtask

  task automatic test_reset_mid_frame;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(50 + i, 200, 1'b1, 1'b1, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (mif.mem_addr !== 14'd0 || o_index !== 4'd0 || o_active !== 1'b0 || o_hsync !== 1'b1 || o_vsync !== 1'b1) begin
      bad++;
      $display("FAIL async_reset got addr=%0d idx=%0d act=%0b hs=%0b vs=%0b want 0 0 0 1 1",
               mif.mem_addr, o_index, o_active, o_hsync, o_vsync);
    end
    @(negedge clk);
    drive(16, 200, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (o_hsync !== 1'b1 || o_vsync !== 1'b1 || mif.mem_addr !== 14'd0) begin
        bad++;
        $display("FAIL held_reset cyc=%0d got hs=%0b vs=%0b addr=%0d want 1 1 0", i, o_hsync, o_vsync, mif.mem_addr);
      end
    end
    rst_n = 1'b1;
    drive(16, 200, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (mif.mem_addr !== 14'd2) begin
      bad++;
      $display("FAIL post_reset_addr got=%0d want=2", mif.mem_addr);
    end
    drive(8, 203, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive(9, 203, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive(8, 204, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (mif.mem_addr !== 14'd81) begin
      bad++;
      $display("FAIL misaligned_addr got=%0d want=81", mif.mem_addr);
    end
    drive(0, 0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (mif.mem_addr !== 14'd0) begin
      bad++;
      $display("FAIL realign_frame_addr got=%0d want=0", mif.mem_addr);
    end
    drive(8, 0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (mif.mem_addr !== 14'd1) begin
      bad++;
      $display("FAIL realign_col8_addr got=%0d want=1", mif.mem_addr);
    end
    drive(9, 0, 1'b0, 1'b1, 1'b1);
    for (int r = 1; r < 4; r++) begin
      @(negedge clk);
      drive(8, r, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      drive(9, r, 1'b0, 1'b1, 1'b1);
    end
    @(negedge clk);
    drive(0, 4, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (mif.mem_addr !== 14'd80) begin
      bad++;
      $display("FAIL realign_row4_addr got=%0d want=80", mif.mem_addr);
    end
  endtask

  initial begin
    drive(0, 0, 1'b0, 1'b1, 1'b1);
    test_reset;
    test_frame_start;
    test_row_advance;
    test_hsync;
    test_reset_mid_frame;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
